// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if -- signal bundle between the VGA timing generator and the
// renderer / display side.
//   master : timing generator (drives counters, syncs, rgb; reads renderer)
//   slave  : renderer / monitor (drives pix_on and colours; reads timing)
// Signals:
//   pix_on       renderer foreground flag for the current hc/vc
//   fg_rgb       foreground colour {R4,G4,B4}
//   bg_rgb       background colour {R4,G4,B4}
//   hc, vc       horizontal / vertical position counters
//   pix_tick     one-clk pixel-rate strobe
//   hsync, vsync registered active-low syncs, aligned with rgb
//   rgb          registered pixel colour
//   frame_start  one-clk pulse at the frame wrap
//   frame_cnt    frame counter, present only with VGA_FRAME_CNT_EN defined
interface vga_sync_gen_if;
  logic        pix_on;
  logic [11:0] fg_rgb;
  logic [11:0] bg_rgb;
  logic [9:0]  hc;
  logic [9:0]  vc;
  logic        pix_tick;
  logic        hsync;
  logic        vsync;
  logic [11:0] rgb;
  logic        frame_start;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  modport master (
    input  pix_on, fg_rgb, bg_rgb,
    output hc, vc, pix_tick, hsync, vsync, rgb, frame_start
`ifdef VGA_FRAME_CNT_EN
    , output frame_cnt
`endif
  );

  modport slave (
    output pix_on, fg_rgb, bg_rgb,
    input  hc, vc, pix_tick, hsync, vsync, rgb, frame_start
`ifdef VGA_FRAME_CNT_EN
    , input  frame_cnt
`endif
  );
endinterface

// File: rtl/vga_sync_gen.sv
// vga_sync_gen -- VGA timing generator with a registered pixel output stage.
// A 2-bit divider produces pix_tick every DIV system clocks; hc/vc advance
// only on pix_tick. Syncs and rgb are registered on pix_tick from the current
// hc/vc, so they lag the counters by exactly one pixel tick.
// Optional feature: define VGA_FRAME_CNT_EN to add the 16-bit frame_cnt
// output (counts frame_start pulses, wraps at 0xFFFF).
// Ports:
//   clk  system clock (single domain)
//   rst  synchronous reset, active-high, dominates every other event
//   vga  vga_sync_gen_if.master bundle (see interface file for signals)
module vga_sync_gen #(
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525,
  parameter int H_SYNC  = 96,
  parameter int V_SYNC  = 2,
  parameter int HBP     = 144,
  parameter int HFP     = 784,
  parameter int VBP     = 35,
  parameter int VFP     = 515,
  parameter int DIV     = 4
) (
  input  logic          clk,
  input  logic          rst,
  vga_sync_gen_if.master vga
);

  // Constants sized to the 10-bit counters so all compares are unsigned
  // and width-matched.
  localparam logic [1:0] DIV_LAST = 2'(DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_C = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_C = 10'(V_SYNC);
  localparam logic [9:0] HBP_C    = 10'(HBP);
  localparam logic [9:0] HFP_C    = 10'(HFP);
  localparam logic [9:0] VBP_C    = 10'(VBP);
  localparam logic [9:0] VFP_C    = 10'(VFP);

  logic [1:0]  div_cnt;
  logic [9:0]  hc;
  logic [9:0]  vc;
  logic        tick;
  logic        h_wrap;
  logic        frame_wrap;
  logic        hs_raw;
  logic        vs_raw;
  logic        video_on;
  logic        hsync_q;
  logic        vsync_q;
  logic [11:0] rgb_q;

  // Tick is gated by rst so nothing downstream sees an event in a reset clk.
  assign tick       = (div_cnt == DIV_LAST) && !rst;
  assign h_wrap     = (hc == H_LAST);
  assign frame_wrap = tick && h_wrap && (vc == V_LAST);

  // Pixel-rate divider
  always_ff @(posedge clk) begin
    if (rst)       div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 2'd1;
  end

  // Position counters; hold between ticks
  always_ff @(posedge clk) begin
    if (rst) begin
      hc <= '0;
      vc <= '0;
    end else if (tick) begin
      if (h_wrap) begin
        hc <= '0;
        vc <= (vc == V_LAST) ? '0 : vc + 10'd1;
      end else begin
        hc <= hc + 10'd1;
      end
    end
  end

  // Raw timing decode from the current position
  always_comb begin
    hs_raw   = (hc >= H_SYNC_C);
    vs_raw   = (vc >= V_SYNC_C);
    video_on = (hc >= HBP_C) && (hc < HFP_C) && (vc >= VBP_C) && (vc < VFP_C);
  end

  // Pixel stage: one tick behind hc/vc; blanking forces black
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      rgb_q   <= 12'h000;
    end else if (tick) begin
      hsync_q <= hs_raw;
      vsync_q <= vs_raw;
      rgb_q   <= video_on ? (vga.pix_on ? vga.fg_rgb : vga.bg_rgb) : 12'h000;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)             frame_cnt_q <= '0;
    else if (frame_wrap) frame_cnt_q <= frame_cnt_q + 16'd1;
  end

  assign vga.frame_cnt = frame_cnt_q;
`endif

  assign vga.hc          = hc;
  assign vga.vc          = vc;
  assign vga.pix_tick    = tick;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.rgb         = rgb_q;
  assign vga.frame_start = frame_wrap;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen using a reduced timing so full frames fit
// in a short run: 20 px/line, 8 lines/frame, hsync 3 px, vsync 2 lines,
// active window hc 5..16, vc 2..6, DIV 4 (one frame = 640 clks).
module tb_vga_sync_gen;
  localparam int HT = 20, VT = 8, HS = 3, VS = 2;
  localparam int HB = 5, HF = 17, VB = 2, VF = 7, DV = 4;
  localparam int FRAME_TICKS = HT * VT;

  logic clk = 1'b0;
  logic rst;
  int   total  = 0;
  int   passed = 0;

  vga_sync_gen_if vif();

  vga_sync_gen #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_SYNC(HS), .V_SYNC(VS),
    .HBP(HB), .HFP(HF), .VBP(VB), .VFP(VF), .DIV(DV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .vga (vif.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clk; sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance through the next pixel tick edge (bounded).
  task automatic next_tick();
    int k;
    k = 0;
    while (!vif.pix_tick && k < 2 * DV) begin
      step();
      k++;
    end
    step();
  endtask

  // Tick until the counters reach (h, v); timeout counts as a failed check.
  task automatic goto(input int h, input int v);
    int n;
    n = 0;
    while (!(vif.hc == 10'(h) && vif.vc == 10'(v)) && n < FRAME_TICKS + 2) begin
      next_tick();
      n++;
    end
    chk($sformatf("goto_%0d_%0d", h, v), {31'd0, (vif.hc == 10'(h) && vif.vc == 10'(v))}, 32'd1);
  endtask

  // First pix_tick exactly DIV clks after reset release, hc=1 afterwards.
  task automatic startup(input string tag);
    for (int k = 1; k <= DV; k++) begin
      chk($sformatf("%s_tick_clk%0d", tag, k), {31'd0, vif.pix_tick}, {31'd0, (k == DV)});
      step();
    end
    chk({tag, "_hc1"}, 32'(vif.hc), 32'd1);
    chk({tag, "_vc0"}, 32'(vif.vc), 32'd0);
  endtask

  initial begin
    int cnt;
    rst        = 1'b1;
    vif.pix_on = 1'b0;
    vif.fg_rgb = 12'hF00;
    vif.bg_rgb = 12'h00F;
    repeat (3) step();

    // Reset state
    chk("rst_hc",    32'(vif.hc), 32'd0);
    chk("rst_vc",    32'(vif.vc), 32'd0);
    chk("rst_tick",  {31'd0, vif.pix_tick}, 32'd0);
    chk("rst_hsync", {31'd0, vif.hsync}, 32'd1);
    chk("rst_vsync", {31'd0, vif.vsync}, 32'd1);
    chk("rst_rgb",   32'(vif.rgb), 32'h000);
    chk("rst_fs",    {31'd0, vif.frame_start}, 32'd0);
`ifdef VGA_FRAME_CNT_EN
    chk("rst_fcnt",  32'(vif.frame_cnt), 32'd0);
`endif

    rst = 1'b0;
    startup("start");

    // Sync registers lag hc/vc by one tick: at hc=1 they show hc=0,vc=0
    chk("hs_at_hc1", {31'd0, vif.hsync}, 32'd0);
    chk("vs_at_hc1", {31'd0, vif.vsync}, 32'd0);
    chk("rgb_blank_line0", 32'(vif.rgb), 32'h000);
    goto(3, 0);
    chk("hs_lag_hc2", {31'd0, vif.hsync}, 32'd0);
    goto(4, 0);
    chk("hs_lag_hc3", {31'd0, vif.hsync}, 32'd1);

    // Line wrap 19->0, vc 0->1
    goto(0, 1);
    chk("hwrap_hc", 32'(vif.hc), 32'd0);
    chk("hwrap_vc", 32'(vif.vc), 32'd1);
    chk("hs_lag_hc19", {31'd0, vif.hsync}, 32'd1);

    // hsync low width over one full line
    cnt = 0;
    for (int k = 0; k < HT; k++) begin
      next_tick();
      if (!vif.hsync) cnt++;
    end
    chk("hs_low_ticks", 32'(cnt), 32'd3);
    chk("vs_lag_vc1", {31'd0, vif.vsync}, 32'd0);
    next_tick();
    chk("vs_lag_vc2", {31'd0, vif.vsync}, 32'd1);

    // Active window colour, horizontal edges on line 2
    vif.pix_on = 1'b1;
    goto(4, 2);
    next_tick();
    chk("rgb_hc4", 32'(vif.rgb), 32'h000);
    next_tick();
    chk("rgb_hc5", 32'(vif.rgb), 32'hF00);
    goto(16, 2);
    next_tick();
    chk("rgb_hc16", 32'(vif.rgb), 32'hF00);
    next_tick();
    chk("rgb_hc17", 32'(vif.rgb), 32'h000);

    // Background when pix_on is low
    vif.pix_on = 1'b0;
    goto(8, 3);
    next_tick();
    chk("rgb_bg", 32'(vif.rgb), 32'h00F);
    vif.pix_on = 1'b1;

    // Vertical edges
    goto(5, 6);
    next_tick();
    chk("rgb_vc6", 32'(vif.rgb), 32'hF00);
    goto(5, 7);
    next_tick();
    chk("rgb_vc7", 32'(vif.rgb), 32'h000);

    // Line wrap alone must not raise frame_start
    goto(19, 3);
    step(); step(); step();
    chk("line_wrap_tick", {31'd0, vif.pix_tick}, 32'd1);
    chk("line_wrap_no_fs", {31'd0, vif.frame_start}, 32'd0);
    step();

    // Frame wrap
    goto(19, 7);
    chk("fs_pre", {31'd0, vif.frame_start}, 32'd0);
    step(); step(); step();
    chk("fs_tick", {31'd0, vif.pix_tick}, 32'd1);
    chk("fs_pulse", {31'd0, vif.frame_start}, 32'd1);
    step();
    chk("fs_after", {31'd0, vif.frame_start}, 32'd0);
    chk("fwrap_hc", 32'(vif.hc), 32'd0);
    chk("fwrap_vc", 32'(vif.vc), 32'd0);
`ifdef VGA_FRAME_CNT_EN
    chk("fcnt_1", 32'(vif.frame_cnt), 32'd1);
`endif

    // Exactly one frame_start clk per frame
    cnt = 0;
    for (int k = 0; k < FRAME_TICKS * DV; k++) begin
      if (vif.frame_start) cnt++;
      step();
    end
    chk("fs_per_frame", 32'(cnt), 32'd1);
`ifdef VGA_FRAME_CNT_EN
    chk("fcnt_2", 32'(vif.frame_cnt), 32'd2);
`endif
    goto(5, 1);
    next_tick();
    chk("rgb_vc1", 32'(vif.rgb), 32'h000);

    // Reset coincident with a pix_tick mid-frame
    goto(10, 4);
    step(); step(); step();
    chk("mid_tick", {31'd0, vif.pix_tick}, 32'd1);
    chk("mid_rgb", 32'(vif.rgb), 32'hF00);
    rst = 1'b1;
    step();
    chk("mrst_hc",    32'(vif.hc), 32'd0);
    chk("mrst_vc",    32'(vif.vc), 32'd0);
    chk("mrst_rgb",   32'(vif.rgb), 32'h000);
    chk("mrst_hsync", {31'd0, vif.hsync}, 32'd1);
    chk("mrst_vsync", {31'd0, vif.vsync}, 32'd1);
    chk("mrst_fs",    {31'd0, vif.frame_start}, 32'd0);
    chk("mrst_tick",  {31'd0, vif.pix_tick}, 32'd0);
`ifdef VGA_FRAME_CNT_EN
    chk("mrst_fcnt",  32'(vif.frame_cnt), 32'd0);
`endif
    rst = 1'b0;
    startup("mrst");

    // Reset coincident with the frame wrap: no pulse, clean restart
    goto(19, 7);
    step(); step(); step();
    rst = 1'b1;
    #1;
    chk("wrst_fs_during", {31'd0, vif.frame_start}, 32'd0);
    step();
    chk("wrst_hc", 32'(vif.hc), 32'd0);
    chk("wrst_vc", 32'(vif.vc), 32'd0);
    chk("wrst_fs", {31'd0, vif.frame_start}, 32'd0);
    rst = 1'b0;
    startup("wrst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter: H_TOTAL, default 800, pixels per line including blanking.
REQ-002 Parameter: V_TOTAL, default 525, lines per frame including blanking.
REQ-003 Parameter: H_SYNC, default 96, hsync low width in pixels; V_SYNC, default 2, vsync low width in lines.
REQ-004 Parameters: HBP 144, HFP 784, VBP 35, VFP 515; active-video window bounds in counter units.
REQ-005 Parameter: DIV, default 4, system clocks per pixel tick (100 MHz to 25 MHz).
REQ-006 clk  input  1  system clock; single clock domain.
REQ-007 rst  input  1  synchronous reset, active-high.
REQ-008 pix_on  input  1  foreground flag from renderer for the current hc/vc (e.g. has_num).
REQ-009 fg_rgb  input  12  foreground colour {R4,G4,B4}; bg_rgb  input  12  background colour.
REQ-010 hc  output  10  horizontal counter, 0..H_TOTAL-1; vc  output  10  vertical counter, 0..V_TOTAL-1.
REQ-011 pix_tick  output  1  one-clk pulse every DIV clocks; hc/vc advance on it.
REQ-012 hsync, vsync  output  1 each  registered sync, active-low, aligned with rgb.
REQ-013 rgb  output  12  registered pixel colour.
REQ-014 frame_start  output  1  one-clk pulse when hc and vc both wrap to 0.

Function
REQ-015 Divider: 2-bit counter div_cnt 0..DIV-1; pix_tick=1 in the clk where div_cnt==DIV-1; div_cnt wraps to 0 in that same clk.
REQ-016 On pix_tick: hc increments; at hc==H_TOTAL-1 hc wraps to 0 and vc increments; at vc==V_TOTAL-1 with hc wrapping, vc wraps to 0.
REQ-017 Between ticks hc/vc hold; no other event changes them.
REQ-018 Raw sync: hs_raw=0 when hc<H_SYNC, else 1; vs_raw=0 when vc<V_SYNC, else 1.
REQ-019 Active window: video_on=1 iff HBP<=hc<HFP and VBP<=vc<VFP; bounds inclusive low, exclusive high.
REQ-020 Pixel stage: on pix_tick, rgb <= video_on ? (pix_on ? fg_rgb : bg_rgb) : 12'h000; hsync<=hs_raw; vsync<=vs_raw; latency exactly one pixel tick from hc/vc.
REQ-021 rgb SHALL be 0 whenever video_on was 0 for the sampled position, regardless of pix_on.
REQ-022 frame_start=1 for exactly one clk, in the clk where the tick wraps hc from H_TOTAL-1 and vc from V_TOTAL-1 to 0.
REQ-023 Counters SHALL never exceed H_TOTAL-1 / V_TOTAL-1; widths fixed at 10 bits, comparisons unsigned.

Reset
REQ-024 rst sampled on rising clk edge; dominates all events including a coincident pix_tick or wrap.
REQ-025 Reset values: div_cnt=0, hc=0, vc=0, pix_tick=0, hsync=1, vsync=1, rgb=12'h000, frame_start=0.
REQ-026 Reset mid-frame restarts at hc=0, vc=0; the first pix_tick occurs DIV clks after rst deasserts; no frame_start pulse is generated by reset itself.

Configuration
REQ-027 Macro VGA_FRAME_CNT_EN: when defined, adds output frame_cnt (16 bits), reset 0, incremented in the frame_start clk, wrapping 0xFFFF to 0.
REQ-028 Without VGA_FRAME_CNT_EN: port frame_cnt and its logic are absent; all other behaviour is identical.

Verification
REQ-029 Reset then run 4 clks -> pix_tick high on clk 4 only; hc=1 afterwards.
REQ-030 Run one full line (3200 clks) -> hc wraps 799->0, vc 0->1; hsync low for exactly 96 ticks (384 clks), one tick delayed from hc.
REQ-031 Run full frame (800*525*4 clks) -> frame_start single-clk pulse at wrap; vsync low for 2 lines; with VGA_FRAME_CNT_EN frame_cnt=1.
REQ-032 pix_on=1, fg=12'hF00, bg=12'h00F: hc=144,vc=35 -> rgb=F00 next tick; hc=143 or hc=784 -> rgb=000.
REQ-033 Assert rst at hc=400,vc=200 coincident with pix_tick -> next clk hc=0, vc=0, rgb=000, hsync=vsync=1, no frame_start.
